// File: rtl/cdb_arbiter.sv
// Writeback stage: per-unit result FIFOs feeding a round-robin arbitrated,
// registered common data bus (CDB) shared by the ROB and reservation stations.
package cdb_pkg;
  localparam int EX_UNITS = 3;
  localparam int ROB_ID_W = 6;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic                ready;
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   rd_data;
  } ex_data_bus_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_EXEC     = EX_UNITS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_mispredict,
  input  ex_data_bus_t      ex_bus [N_EXEC],
  output logic [N_EXEC-1:0] ex_stall,
  output ex_data_bus_t      cdb
);
  // Handshake per unit i: a result is taken at the clock edge when
  // ex_bus[i].ready && !ex_stall[i]; while stalled the unit keeps presenting
  // the same result, so each result is accepted exactly once.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (N_EXEC > 1) ? $clog2(N_EXEC) : 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   rd_data;
  } entry_t;

  entry_t            mem    [N_EXEC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [N_EXEC];
  logic [PTR_W-1:0]  rd_ptr [N_EXEC];
  logic [CNT_W-1:0]  count  [N_EXEC];
  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   rr_next;
  logic [N_EXEC-1:0] push;
  logic [N_EXEC-1:0] pop;
  logic [N_EXEC-1:0] not_empty;
  logic              grant_valid;
  entry_t            head;

  // Stall looks only at the registered count, so a full FIFO stalls even when
  // it is about to pop; this keeps ex_bus.ready out of the stall path.
  always_comb begin
    for (int i = 0; i < N_EXEC; i++) begin
      ex_stall[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      not_empty[i] = (count[i] != '0);
      push[i]      = ex_bus[i].ready && !ex_stall[i] && !branch_mispredict;
    end
  end

  // Round-robin scan starting at rr_ptr; the first non-empty FIFO wins.
  always_comb begin
    grant_valid = 1'b0;
    pop         = '0;
    rr_next     = rr_ptr;
    head        = '0;
    for (int k = 0; k < N_EXEC; k++) begin
      for (int i = 0; i < N_EXEC; i++) begin
        if (!grant_valid && not_empty[i] && (((int'(rr_ptr) + k) % N_EXEC) == i)) begin
          grant_valid = 1'b1;
          pop[i]      = 1'b1;
          rr_next     = RR_W'((i + 1) % N_EXEC);
          head        = mem[i][rd_ptr[i]];
        end
      end
    end
  end

  // A flush drops everything, including this cycle's pop and pushes.
  always_ff @(posedge clk) begin
    if (rst || branch_mispredict) begin
      for (int i = 0; i < N_EXEC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_EXEC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      if (grant_valid) rr_ptr <= rr_next;
    end
  end

  // Payload storage needs no reset: pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EXEC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {ex_bus[i].rob_id, ex_bus[i].rd_data};
    end
  end

  // rob_id/rd_data hold across idle cycles; only ready pulses per result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb <= '0;
    end else if (branch_mispredict) begin
      cdb.ready <= 1'b0;
    end else if (grant_valid) begin
      cdb <= {1'b1, head.rob_id, head.rd_data};
    end else begin
      cdb.ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the writeback stage.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 3;
  localparam int D = 2;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   rd_data;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         branch_mispredict = 1'b0;
  ex_data_bus_t bus [N];
  logic [N-1:0] ex_stall;
  ex_data_bus_t cdb;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of pending results per unit.
  res_t         mq [N][$];
  int           m_rr = 0;
  ex_data_bus_t m_cdb = '0;
  logic [N-1:0] m_acc = '0;

  cdb_arbiter #(.N_EXEC(N), .FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_mispredict(branch_mispredict),
    .ex_bus           (bus),
    .ex_stall         (ex_stall),
    .cdb              (cdb)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_stall_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (mq[i].size() == D);
    return v;
  endfunction

  // One clock edge of the model, from the inputs currently driven.
  task automatic model_edge();
    bit   found;
    int   g;
    res_t e;
    m_acc = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr  = 0;
      m_cdb = '0;
    end else if (branch_mispredict) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr        = 0;
      m_cdb.ready = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) m_acc[i] = bus[i].ready && (mq[i].size() < D);
      found = 0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && mq[(m_rr + k) % N].size() > 0) begin
          found = 1;
          g     = (m_rr + k) % N;
        end
      end
      if (found) begin
        e     = mq[g].pop_front();
        m_cdb = {1'b1, e.rob_id, e.rd_data};
        m_rr  = (g + 1) % N;
      end else begin
        m_cdb.ready = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (m_acc[i]) mq[i].push_back({bus[i].rob_id, bus[i].rd_data});
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    for (int i = 0; i < N; i++) bus[i] = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    branch_mispredict = 1'b0;
    idle_bus();
    tick();
    tick();
    checks++;
    if (cdb !== '0) begin errors++; $display("FAIL reset_cdb got %h want 0", cdb); end
    checks++;
    if (ex_stall !== '0) begin errors++; $display("FAIL reset_stall got %b want 0", ex_stall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    ex_data_bus_t want;
    want = {1'b1, ROB_ID_W'(5), 32'hDEAD_BEEF};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_bus();
      if (c == 0) bus[0] = want;
      tick();
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL single_model c=%0d got %h want %h", c, cdb, m_cdb); end
      checks++;
      if (c == 1) begin
        if (cdb !== want) begin errors++; $display("FAIL single_beat got %h want %h", cdb, want); end
      end else if (cdb.ready !== 1'b0) begin
        errors++; $display("FAIL single_idle c=%0d ready=%b want 0", c, cdb.ready);
      end
      checks++;
      if (ex_stall !== '0) begin errors++; $display("FAIL single_stall got %b want 0", ex_stall); end
    end
  endtask

  task automatic test_contention();
    int exp_rob [7] = '{-1, 1, 2, 3, -1, 6, 7};
    @(negedge clk);
    rst = 1'b1;
    idle_bus();
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk);
      idle_bus();
      if (c == 0)
        for (int i = 0; i < N; i++) bus[i] = {1'b1, ROB_ID_W'(i + 1), DATA_W'($urandom)};
      // Units 2 and 0 together: unit 0 first shows the pointer is back at 0.
      if (c == 4) begin
        bus[2] = {1'b1, ROB_ID_W'(7), DATA_W'($urandom)};
        bus[0] = {1'b1, ROB_ID_W'(6), DATA_W'($urandom)};
      end
      tick();
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL contention_model c=%0d got %h want %h", c, cdb, m_cdb); end
      checks++;
      if (exp_rob[c] < 0) begin
        if (cdb.ready !== 1'b0) begin errors++; $display("FAIL contention_idle c=%0d ready=%b want 0", c, cdb.ready); end
      end else if (cdb.ready !== 1'b1 || cdb.rob_id !== ROB_ID_W'(exp_rob[c])) begin
        errors++;
        $display("FAIL contention_order c=%0d got ready=%b rob=%0d want rob=%0d", c, cdb.ready, cdb.rob_id, exp_rob[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ROB_ID_W-1:0] exp0_q [$];
    logic [ROB_ID_W-1:0] exp1_q [$];
    logic [ROB_ID_W-1:0] got;
    int nid0 = 40;
    int nid1 = 10;
    int prev_unit = -1;
    int unit;
    bit saw_stall1 = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idle_bus();
      if (c < 24) begin
        bus[0] = {1'b1, ROB_ID_W'(nid0), DATA_W'(nid0 * 3)};
        bus[1] = {1'b1, ROB_ID_W'(nid1), DATA_W'(nid1 * 7)};
      end
      tick();
      if (m_acc[0]) begin exp0_q.push_back(ROB_ID_W'(nid0)); nid0++; end
      if (m_acc[1]) begin exp1_q.push_back(ROB_ID_W'(nid1)); nid1++; end
      if (ex_stall[1] === 1'b1) saw_stall1 = 1;
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL bp_model c=%0d got %h want %h", c, cdb, m_cdb); end
      checks++;
      if (ex_stall !== m_stall_vec()) begin errors++; $display("FAIL bp_stall c=%0d got %b want %b", c, ex_stall, m_stall_vec()); end
      if (cdb.ready === 1'b1) begin
        got  = cdb.rob_id;
        unit = (got >= 40) ? 0 : 1;
        checks++;
        if (unit == 0) begin
          if (exp0_q.size() == 0 || exp0_q[0] !== got) begin errors++; $display("FAIL bp_order0 got %0d", got); end
          else void'(exp0_q.pop_front());
        end else begin
          if (exp1_q.size() == 0 || exp1_q[0] !== got) begin errors++; $display("FAIL bp_order1 got %0d", got); end
          else void'(exp1_q.pop_front());
        end
        if (c < 24 && prev_unit >= 0) begin
          checks++;
          if (unit == prev_unit) begin errors++; $display("FAIL bp_alternate c=%0d unit %0d twice", c, unit); end
        end
        prev_unit = unit;
      end
    end
    checks++;
    if (saw_stall1 !== 1'b1) begin errors++; $display("FAIL bp_stall1_seen got 0 want 1"); end
    checks++;
    if (exp0_q.size() + exp1_q.size() != 0) begin
      errors++; $display("FAIL bp_drain got %0d undelivered want 0", exp0_q.size() + exp1_q.size());
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      idle_bus();
      if (c < 9) bus[2] = {1'b1, ROB_ID_W'(20 + c), DATA_W'($urandom)};
      tick();
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL wrap_model c=%0d got %h want %h", c, cdb, m_cdb); end
      checks++;
      if (ex_stall[2] !== 1'b0) begin errors++; $display("FAIL wrap_stall c=%0d got 1 want 0", c); end
      checks++;
      if (c >= 1 && c <= 9) begin
        if (cdb.ready !== 1'b1 || cdb.rob_id !== ROB_ID_W'(19 + c)) begin
          errors++; $display("FAIL wrap_beat c=%0d got ready=%b rob=%0d want rob=%0d", c, cdb.ready, cdb.rob_id, 19 + c);
        end
      end else if (cdb.ready !== 1'b0) begin
        errors++; $display("FAIL wrap_idle c=%0d ready=%b want 0", c, cdb.ready);
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_bus();
      branch_mispredict = 1'b0;
      if (c < 2) begin
        bus[0] = {1'b1, ROB_ID_W'(30 + 2 * c), DATA_W'($urandom)};
        bus[1] = {1'b1, ROB_ID_W'(31 + 2 * c), DATA_W'($urandom)};
      end
      if (c == 2) begin
        bus[0] = {1'b1, ROB_ID_W'(34), DATA_W'($urandom)};
        branch_mispredict = 1'b1;
      end
      tick();
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL flush_model c=%0d got %h want %h", c, cdb, m_cdb); end
      if (c >= 2) begin
        checks++;
        if (cdb.ready !== 1'b0) begin errors++; $display("FAIL flush_leak c=%0d rob=%0d ready=%b want 0", c, cdb.rob_id, cdb.ready); end
        checks++;
        if (ex_stall !== '0) begin errors++; $display("FAIL flush_stall c=%0d got %b want 0", c, ex_stall); end
      end
    end
    @(negedge clk);
    branch_mispredict = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_bus();
      rst = (c == 1);
      if (c == 0)
        for (int i = 0; i < N; i++) bus[i] = {1'b1, ROB_ID_W'(50 + i), DATA_W'($urandom)};
      if (c == 2) bus[1] = {1'b1, ROB_ID_W'(53), 32'h0};
      tick();
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL rstmid_model c=%0d got %h want %h", c, cdb, m_cdb); end
      checks++;
      if (c == 1) begin
        if (cdb !== '0 || ex_stall !== '0) begin errors++; $display("FAIL rstmid_values cdb=%h stall=%b want 0", cdb, ex_stall); end
      end else if (c == 3) begin
        if (cdb !== {1'b1, ROB_ID_W'(53), 32'h0}) begin errors++; $display("FAIL rstmid_fresh got %h want rob 53", cdb); end
      end else if (c > 1 && cdb.ready !== 1'b0) begin
        errors++; $display("FAIL rstmid_idle c=%0d ready=%b want 0", c, cdb.ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit   pend [N];
    res_t val  [N];
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      rst               = (c < 400) && ($urandom_range(0, 149) == 0);
      branch_mispredict = (c < 400) && ($urandom_range(0, 24) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && c < 400 && $urandom_range(0, 99) < 55) begin
          pend[i] = 1;
          val[i]  = {ROB_ID_W'($urandom_range(0, 63)),
                     ($urandom_range(0, 3) == 0) ? DATA_W'(0) : DATA_W'($urandom)};
        end
        bus[i] = pend[i] ? {1'b1, val[i].rob_id, val[i].rd_data} : '0;
      end
      tick();
      for (int i = 0; i < N; i++) if (m_acc[i] || rst || branch_mispredict) pend[i] = 0;
      checks++;
      if (cdb !== m_cdb) begin errors++; $display("FAIL random_cdb c=%0d got %h want %h", c, cdb, m_cdb); end
      checks++;
      if (ex_stall !== m_stall_vec()) begin errors++; $display("FAIL random_stall c=%0d got %b want %b", c, ex_stall, m_stall_vec()); end
    end
    @(negedge clk);
    rst = 1'b0;
    branch_mispredict = 1'b0;
    idle_bus();
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
